// File: rtl/exec_retire_arbiter_pkg.sv
// Shared execution-cluster definitions: opcode classes, field widths and the
// order-queue / retire-port record layouts used by the retire arbiter.
package exec_retire_arbiter_pkg;

    localparam int UNIT_W  = 3;   // wide enough for up to 8 execution units
    localparam int RD_W    = 5;
    localparam int CAUSE_W = 4;

    typedef enum logic [1:0] {
        OP_ALU,
        OP_MUL,
        OP_LSU,
        OP_BRANCH
    } exec_op_e;

    typedef struct packed {
        logic [UNIT_W-1:0] unit;
        logic [RD_W-1:0]   rd;
        logic              reg_write;
    } order_entry_t;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                exception;
        logic [UNIT_W-1:0]   unit;
        logic [RD_W-1:0]     rd;
        logic [CAUSE_W-1:0]  trap_cause;
    } retire_port_t;

endpackage

// File: rtl/exec_retire_arbiter_fifo.sv
// Generic power-of-two FIFO with occupancy count and synchronous clear;
// push while full is accepted only when a pop happens in the same cycle.
module order_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/exec_retire_arbiter.sv
// In-order retire arbiter: records issue order, serves only the unit owning the
// oldest entry, and presents one registered writeback per cycle.
import exec_retire_arbiter_pkg::*;

module exec_retire_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int DEPTH     = 4,
    parameter int XLEN      = 64,
    localparam int UW       = $clog2(NUM_UNITS),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [UW-1:0]             issue_unit,
    input  logic [4:0]                issue_rd,
    input  logic                      issue_reg_write,
    output logic                      issue_ready,
    input  logic [NUM_UNITS-1:0]      unit_valid,
    input  logic [NUM_UNITS-1:0]      unit_exception,
    input  logic [4*NUM_UNITS-1:0]    unit_trap_cause,
    input  logic [XLEN*NUM_UNITS-1:0] unit_result,
    output logic [NUM_UNITS-1:0]      unit_ready,
    output logic                      wb_valid,
    output logic                      wb_reg_write,
    output logic                      wb_exception,
    output logic [4:0]                wb_rd,
    output logic [UW-1:0]             wb_unit,
    output logic [3:0]                wb_trap_cause,
    output logic [XLEN-1:0]           wb_result,
    input  logic                      wb_ready,
    input  logic                      flush,
    output logic [CW-1:0]             occupancy,
    output logic                      protocol_error
);
    order_entry_t     push_entry, head;
    logic             fifo_full, fifo_empty;
    logic [UW-1:0]    head_unit;
    logic             out_free, head_sel, retire;
    logic             issue_fire, issue_bad, push;
    retire_port_t     wb_q, wb_d;
    logic [XLEN-1:0]  wb_result_q, wb_result_d;
    logic             protocol_error_q, protocol_error_d;
    logic             unused_wb_unit;

    assign head_unit   = head.unit[UW-1:0];
    assign out_free    = !wb_q.valid || wb_ready;
    assign head_sel    = !fifo_empty && out_free && !flush;
    assign retire      = head_sel && unit_valid[head_unit];
    // A full queue still takes an issue when the head leaves in the same cycle.
    assign issue_ready = !flush && (!fifo_full || retire);
    assign issue_fire  = issue_valid && issue_ready;
    assign issue_bad   = int'(issue_unit) >= NUM_UNITS;
    assign push        = issue_fire && !issue_bad;
    assign push_entry  = '{unit: UNIT_W'(issue_unit), rd: issue_rd, reg_write: issue_reg_write};

    order_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(order_entry_t))
    ) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .din   (push_entry),
        .pop   (retire),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    always_comb begin
        unit_ready = '0;
        if (head_sel)
            unit_ready[head_unit] = 1'b1;
    end

    always_comb begin
        wb_d             = wb_q;
        wb_result_d      = wb_result_q;
        protocol_error_d = protocol_error_q || (issue_fire && issue_bad);
        if (flush) begin
            wb_d.valid = 1'b0;
        end else if (retire) begin
            wb_d.valid      = 1'b1;
            wb_d.unit       = head.unit;
            wb_d.rd         = head.rd;
            wb_d.exception  = unit_exception[head_unit];
            // x0 is never written, and a faulting op never updates its rd.
            wb_d.reg_write  = head.reg_write && (head.rd != '0) && !unit_exception[head_unit];
            wb_d.trap_cause = unit_trap_cause[CAUSE_W*int'(head_unit) +: CAUSE_W];
            wb_result_d     = unit_result[XLEN*int'(head_unit) +: XLEN];
        end else if (wb_ready) begin
            wb_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q             <= '0;
            wb_result_q      <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            wb_q             <= wb_d;
            wb_result_q      <= wb_result_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign wb_valid       = wb_q.valid;
    assign wb_reg_write   = wb_q.reg_write;
    assign wb_exception   = wb_q.exception;
    assign wb_rd          = wb_q.rd;
    assign wb_unit        = wb_q.unit[UW-1:0];
    assign wb_trap_cause  = wb_q.trap_cause;
    assign wb_result      = wb_result_q;
    assign protocol_error = protocol_error_q;
    assign unused_wb_unit = ^wb_q.unit;

endmodule

// File: tb/tb_exec_retire_arbiter.sv
// Bench for exec_retire_arbiter: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_exec_retire_arbiter;
    // Five units so that an out-of-range unit index (7) is representable.
    localparam int NU  = 5;
    localparam int DP  = 4;
    localparam int XL  = 64;
    localparam int UW  = $clog2(NU);
    localparam int CW  = $clog2(DP) + 1;
    localparam int CTW = 4 * NU;

    logic              clk, rst;
    logic              issue_valid, issue_reg_write, issue_ready;
    logic [UW-1:0]     issue_unit;
    logic [4:0]        issue_rd;
    logic [NU-1:0]     unit_valid, unit_exception, unit_ready;
    logic [CTW-1:0]    unit_trap_cause;
    logic [XL*NU-1:0]  unit_result;
    logic              wb_valid, wb_reg_write, wb_exception, wb_ready, flush, protocol_error;
    logic [4:0]        wb_rd;
    logic [UW-1:0]     wb_unit;
    logic [3:0]        wb_trap_cause;
    logic [XL-1:0]     wb_result;
    logic [CW-1:0]     occupancy;

    exec_retire_arbiter #(.NUM_UNITS(NU), .DEPTH(DP), .XLEN(XL)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_rd(issue_rd),
        .issue_reg_write(issue_reg_write), .issue_ready(issue_ready),
        .unit_valid(unit_valid), .unit_exception(unit_exception),
        .unit_trap_cause(unit_trap_cause), .unit_result(unit_result), .unit_ready(unit_ready),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_exception(wb_exception),
        .wb_rd(wb_rd), .wb_unit(wb_unit), .wb_trap_cause(wb_trap_cause),
        .wb_result(wb_result), .wb_ready(wb_ready),
        .flush(flush), .occupancy(occupancy), .protocol_error(protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: program-order queue plus one writeback slot.
    int          mq_unit[$], mq_rd[$];
    bit          mq_rw[$];
    bit          m_valid = 0, m_rw = 0, m_exc = 0, m_perr = 0;
    int          m_unit = 0, m_rd = 0;
    logic [3:0]  m_cause = '0;
    logic [63:0] m_res = '0;

    always @(negedge clk) begin
        bit m_free, m_sel, m_ret, m_iready;
        int h;
        h        = (mq_unit.size() > 0) ? mq_unit[0] : 0;
        m_free   = !m_valid || wb_ready;
        m_sel    = (mq_unit.size() > 0) && m_free && !flush;
        m_ret    = m_sel && unit_valid[h];
        m_iready = !flush && ((mq_unit.size() < DP) || m_ret);

        chk("m.occupancy", 64'(occupancy), 64'(mq_unit.size()));
        chk("m.issue_ready", 64'(issue_ready), 64'(m_iready));
        chk("m.unit_ready", 64'(unit_ready), m_sel ? (64'd1 << h) : 64'd0);
        chk("m.protocol_error", 64'(protocol_error), 64'(m_perr));
        chk("m.wb_valid", 64'(wb_valid), 64'(m_valid));
        if (m_valid) begin
            chk("m.wb_unit", 64'(wb_unit), 64'(m_unit));
            chk("m.wb_rd", 64'(wb_rd), 64'(m_rd));
            chk("m.wb_reg_write", 64'(wb_reg_write), 64'(m_rw));
            chk("m.wb_exception", 64'(wb_exception), 64'(m_exc));
            chk("m.wb_trap_cause", 64'(wb_trap_cause), 64'(m_cause));
            chk("m.wb_result", wb_result, m_res);
        end

        if (rst) begin
            mq_unit.delete(); mq_rd.delete(); mq_rw.delete();
            m_valid = 0; m_perr = 0;
        end else if (flush) begin
            mq_unit.delete(); mq_rd.delete(); mq_rw.delete();
            m_valid = 0;
        end else begin
            if (m_ret) begin
                m_valid = 1;
                m_unit  = h;
                m_rd    = mq_rd[0];
                m_exc   = unit_exception[h];
                m_rw    = mq_rw[0] && (m_rd != 0) && !m_exc;
                m_cause = unit_trap_cause[h*4 +: 4];
                m_res   = unit_result[h*XL +: XL];
                void'(mq_unit.pop_front()); void'(mq_rd.pop_front()); void'(mq_rw.pop_front());
            end else if (wb_ready) begin
                m_valid = 0;
            end
            if (issue_valid && m_iready) begin
                if (int'(issue_unit) >= NU) m_perr = 1;
                else begin
                    mq_unit.push_back(int'(issue_unit));
                    mq_rd.push_back(int'(issue_rd));
                    mq_rw.push_back(issue_reg_write);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; unit_valid = '0; unit_exception = '0;
        flush = 1'b0; wb_ready = 1'b1;
    endtask

    task automatic issue(input int u, input int rd, input bit rw);
        issue_valid = 1'b1; issue_unit = UW'(u); issue_rd = 5'(rd); issue_reg_write = rw;
    endtask

    task automatic set_defaults();
        for (int i = 0; i < NU; i++) begin
            unit_result[i*XL +: XL]  = 64'h1000 + 64'(i);
            unit_trap_cause[i*4 +: 4] = 4'(i);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".occupancy"}, 64'(occupancy), 0);
        chk({tag, ".wb_valid"}, 64'(wb_valid), 0);
        chk({tag, ".wb_reg_write"}, 64'(wb_reg_write), 0);
        chk({tag, ".wb_exception"}, 64'(wb_exception), 0);
        chk({tag, ".wb_rd"}, 64'(wb_rd), 0);
        chk({tag, ".wb_unit"}, 64'(wb_unit), 0);
        chk({tag, ".protocol_error"}, 64'(protocol_error), 0);
    endtask

    initial begin
        rst = 1'b1; idle();
        issue_unit = '0; issue_rd = '0; issue_reg_write = 1'b0;
        unit_result = '0; unit_trap_cause = '0;
        set_defaults();
        tick(); tick();
        rst = 1'b0;
        #1 chk_reset_state("reset");

        // Out-of-order completion retires in issue order.
        issue(2, 5, 1); tick(); issue(0, 6, 1); tick(); issue(1, 7, 1); tick();
        idle(); unit_valid = 5'b00010;
        #1 chk("order.unit1_held", 64'(unit_ready), 64'b00100);
        chk("order.occ3", 64'(occupancy), 3);
        tick();
        unit_valid = 5'b00011; tick();
        unit_valid = 5'b00111; tick();
        unit_valid = 5'b00011;
        #1 chk("order.wb0_unit", 64'(wb_unit), 2); chk("order.wb0_rd", 64'(wb_rd), 5);
        tick();
        unit_valid = 5'b00010;
        #1 chk("order.wb1_unit", 64'(wb_unit), 0); chk("order.wb1_rd", 64'(wb_rd), 6);
        tick();
        idle();
        #1 chk("order.wb2_unit", 64'(wb_unit), 1); chk("order.wb2_rd", 64'(wb_rd), 7);
        chk("order.wb2_result", wb_result, 64'h1001);
        tick();

        // Full queue: issue only alongside a retire.
        issue(0, 1, 1); tick(); issue(1, 2, 1); tick(); issue(2, 3, 1); tick(); issue(3, 4, 1); tick();
        issue(4, 8, 1);
        #1 chk("full.occ", 64'(occupancy), 4); chk("full.issue_ready", 64'(issue_ready), 0);
        tick();
        unit_valid = 5'b00001;
        #1 chk("full.issue_ready_retire", 64'(issue_ready), 1);
        tick();
        idle();
        #1 chk("full.occ_kept", 64'(occupancy), 4); chk("full.wb_rd", 64'(wb_rd), 1);
        unit_valid = '1; repeat (4) tick();
        idle();
        #1 chk("full.drained", 64'(occupancy), 0); chk("full.last_rd", 64'(wb_rd), 8);
        chk("full.last_unit", 64'(wb_unit), 4);
        tick();

        // Writeback backpressure.
        unit_result[1*XL +: XL] = 64'hDEAD;
        issue(1, 9, 1); tick(); issue(2, 10, 1); tick();
        idle(); unit_valid = 5'b00110; tick();
        wb_ready = 1'b0;
        repeat (3) begin
            #1 chk("stall.wb_valid", 64'(wb_valid), 1); chk("stall.result", wb_result, 64'hDEAD);
            chk("stall.rd", 64'(wb_rd), 9); chk("stall.unit_ready", 64'(unit_ready), 0);
            tick();
        end
        wb_ready = 1'b1;
        #1 chk("stall.release", 64'(unit_ready), 64'b00100);
        tick();
        idle();
        #1 chk("stall.next_rd", 64'(wb_rd), 10); chk("stall.next_unit", 64'(wb_unit), 2);
        tick();
        set_defaults();

        // Exception then flush.
        issue(3, 11, 1); tick(); issue(0, 12, 1); tick();
        idle(); unit_valid = 5'b01000; unit_exception = 5'b01000; unit_trap_cause[12 +: 4] = 4'd5;
        tick();
        idle(); flush = 1'b1;
        #1 chk("exc.wb_exception", 64'(wb_exception), 1); chk("exc.cause", 64'(wb_trap_cause), 5);
        chk("exc.reg_write", 64'(wb_reg_write), 0); chk("exc.issue_ready", 64'(issue_ready), 0);
        tick();
        idle();
        #1 chk("flush.occ", 64'(occupancy), 0); chk("flush.wb_valid", 64'(wb_valid), 0);
        tick();
        set_defaults();

        // rd==0 suppresses write; bad unit index raises sticky error.
        issue(4, 0, 1); tick();
        idle(); unit_valid = 5'b10000; tick();
        idle();
        #1 chk("x0.wb_valid", 64'(wb_valid), 1); chk("x0.reg_write", 64'(wb_reg_write), 0);
        tick();
        issue(7, 20, 1);
        #1 chk("perr.issue_ready", 64'(issue_ready), 1);
        tick();
        idle();
        #1 chk("perr.set", 64'(protocol_error), 1); chk("perr.occ", 64'(occupancy), 0);
        repeat (3) tick();
        chk("perr.sticky", 64'(protocol_error), 1);

        // Reset mid-drain.
        issue(0, 1, 1); tick(); issue(1, 2, 1); tick(); issue(2, 3, 1); tick(); issue(3, 4, 1); tick();
        idle(); wb_ready = 1'b0; unit_valid = 5'b00001; tick();
        idle(); wb_ready = 1'b0;
        #1 chk("rstmid.occ", 64'(occupancy), 3); chk("rstmid.wb_valid", 64'(wb_valid), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        #1 chk_reset_state("rstmid");

        // Random traffic, wrapping the pointers many times.
        for (int c = 0; c < 80; c++) begin
            issue_valid     = 1'($urandom_range(0, 1));
            issue_unit      = UW'($urandom_range(0, NU - 1));
            issue_rd        = 5'($urandom_range(0, 31));
            issue_reg_write = 1'($urandom_range(0, 1));
            unit_valid      = NU'($urandom);
            unit_exception  = ($urandom_range(0, 7) == 0) ? NU'($urandom) : '0;
            wb_ready        = ($urandom_range(0, 3) != 0);
            unit_trap_cause = CTW'($urandom);
            for (int i = 0; i < NU; i++) unit_result[i*XL +: XL] = {$urandom(), $urandom()};
            tick();
        end
        idle(); repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
